// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } arb_state_e;

    // Load/store size/sign code, same encoding as the LSU/control unit
    typedef logic [2:0] ldst_op_t;

    // Read data returned on a response timeout
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [1:0]                       req_valid;
    logic [1:0]                       req_ready;
    logic [1:0][AW-1:0]               req_addr;
    logic [1:0][DW-1:0]               req_wdata;
    logic [1:0]                       req_we;
    dmem_arb_pkg::ldst_op_t [1:0]     req_op;
    logic [1:0]                       rsp_valid;
    logic [DW-1:0]                    rsp_rdata;
    logic                             rsp_err;
    logic                             mem_req;
    logic                             mem_gnt;
    logic [AW-1:0]                    mem_addr;
    logic [DW-1:0]                    mem_wdata;
    logic                             mem_we;
    dmem_arb_pkg::ldst_op_t           mem_op;
    logic                             mem_rvalid;
    logic [DW-1:0]                    mem_rdata;
    logic                             spurious;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_op,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_addr, mem_wdata, mem_we, mem_op, spurious
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_op,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_addr, mem_wdata, mem_we, mem_op, spurious
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone valid port wins; on a tie the port
// that did not win last time wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // One-hot grant from request vector and previous winner
    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core LSU (port 0) and the
// debug/DMA loader (port 1). One transaction outstanding at a time.
// Optional build macro DMEM_ARB_TIMEOUT_EN: bounds the response wait to TIMEOUT
// cycles and returns an error response when it expires.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dmem_arbiter_if.slave  bus
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] grant;
    logic       winner;
    logic       do_grant;
    logic       timeout;

    rr_arb2 u_rr_arb2 (
        .valid_i      (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign winner   = grant[1];
    assign do_grant = (state_q == StIdle) && (|bus.req_valid) && bus.mem_gnt;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires on the TIMEOUT-th WAIT cycle
    assign timeout = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

    // Wait counter: cleared when entering WAIT, counts every WAIT cycle
    always_comb begin
        cnt_d = cnt_q;
        if (do_grant) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;

    // TIMEOUT only matters in the timeout build
    if (TIMEOUT == 0) begin : g_no_timeout
    end
`endif

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: grant moves to WAIT, response (or timeout) returns to IDLE
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (do_grant) begin
                    state_d      = StWait;
                    owner_d      = winner;
                    last_grant_d = winner;
                end
            end
            StWait: begin
                if (bus.mem_rvalid || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: request mux in IDLE, response routing in WAIT; all quiet in reset
    always_comb begin
        logic [1:0]    req_ready;
        logic [1:0]    rsp_valid;
        logic [DW-1:0] rsp_rdata;
        logic          rsp_err;
        logic          mem_req;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          mem_we;
        ldst_op_t      mem_op;
        logic          spurious;

        req_ready = 2'b00;
        rsp_valid = 2'b00;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_op    = '0;
        spurious  = 1'b0;

        if (rst_ni) begin
            unique case (state_q)
                StIdle: begin
                    if (|bus.req_valid) begin
                        mem_req   = 1'b1;
                        mem_addr  = bus.req_addr[winner];
                        mem_wdata = bus.req_wdata[winner];
                        mem_we    = bus.req_we[winner];
                        mem_op    = bus.req_op[winner];
                        if (bus.mem_gnt) begin
                            req_ready[winner] = 1'b1;
                        end
                    end
                    spurious = bus.mem_rvalid;
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        rsp_valid[owner_q] = 1'b1;
                        rsp_rdata          = bus.mem_rdata;
                    end else if (timeout) begin
`ifdef DMEM_ARB_TIMEOUT_EN
                        rsp_valid[owner_q] = 1'b1;
                        rsp_rdata          = DW'(TIMEOUT_RDATA);
                        rsp_err            = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

        bus.req_ready = req_ready;
        bus.rsp_valid = rsp_valid;
        bus.rsp_rdata = rsp_rdata;
        bus.rsp_err   = rsp_err;
        bus.mem_req   = mem_req;
        bus.mem_addr  = mem_addr;
        bus.mem_wdata = mem_wdata;
        bus.mem_we    = mem_we;
        bus.mem_op    = mem_op;
        bus.spurious  = spurious;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/IO port (LSU memory side) between two requesters: port 0 = core load/store path, port 1 = debug/DMA loader.
- Round-robin arbitration with valid/ready request handshakes.
- Allows one outstanding transaction; the response is routed back to the owning port.
- Sits between the core's load/store unit, the debug loader and the data memory/peripheral bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, response-wait limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  2  per-port request valid.
- req_ready_o  out  2  per-port request accepted, same cycle.
- req_addr_i  in  2xAW  per-port byte address, packed [1:0][AW-1:0].
- req_wdata_i  in  2xDW  per-port store data.
- req_we_i  in  2  per-port write enable.
- req_op_i  in  2x3  per-port load/store size/sign code, passed through unchanged.
- rsp_valid_o  out  2  per-port response pulse.
- rsp_rdata_o  out  DW  response data, shared; valid only with rsp_valid_o.
- rsp_err_o  out  1  response error flag, qualified by rsp_valid_o.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_addr_o  out  AW  address to memory.
- mem_wdata_o  out  DW  store data to memory.
- mem_we_o  out  1  write enable to memory.
- mem_op_o  out  3  load/store code to memory.
- mem_rvalid_i  in  1  memory response valid; one per granted request, reads and writes.
- mem_rdata_i  in  DW  memory read data.
- spurious_o  out  1  pulse: mem_rvalid_i arrived with no transaction outstanding.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE, last_grant=1 (port 0 wins the first tie), owner=0, timeout counter=0.
  - All outputs 0 during and after reset until a new request.
- FSM states:
  - IDLE: winner = the only valid port; if both valid, the port != last_grant.
    - mem_req_o=1 and mem_addr/wdata/we/op = winner's fields, combinationally.
    - If mem_gnt_i: req_ready_o[winner]=1, owner<=winner, last_grant<=winner, go WAIT.
    - No valid request: mem_req_o=0, mem_* data outputs driven 0.
  - WAIT: mem_req_o=0, req_ready_o=0.
    - On mem_rvalid_i: rsp_valid_o[owner]=1, rsp_rdata_o=mem_rdata_i, rsp_err_o=0, combinationally; go IDLE.
- Latency:
  - Request acceptance is 0 cycles after valid once mem_gnt_i arrives.
  - The response pulse appears in the same cycle as mem_rvalid_i.
  - New arbitration happens the cycle after a response; minimum 2 cycles per transaction.
- Requester rule: fields must stay stable while valid && !ready. The winner may change between IDLE cycles until a grant occurs; the bench asserts this.
- Write responses: write transactions also wait for mem_rvalid_i; rsp_rdata_o = mem_rdata_i, don't-care to the requester.
- Spurious responses: mem_rvalid_i in IDLE gives spurious_o=1 for one cycle; no rsp_valid_o.
- Simultaneous events: mem_rvalid_i in WAIT with new requests pending completes the response only. Arbitration resumes next cycle using the updated last_grant.
- Reset mid-WAIT: the outstanding response is dropped; a later mem_rvalid_i is reported as spurious.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1.

Optional Feature:
- DMEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT with no mem_rvalid_i: rsp_valid_o[owner]=1, rsp_rdata_o=32'hDEAD_BEEF, rsp_err_o=1, go IDLE.
  - A late response after a timeout is reported as spurious.
  - If mem_rvalid_i and the timeout occur in the same cycle, the real response wins.
- Not defined: WAIT lasts until mem_rvalid_i with no limit; rsp_err_o tied 0; no counter logic.

Decomposition:
- Package dmem_arb_pkg:
  - typedef arb_state_e {IDLE, WAIT};
  - typedef ldst_op_t logic[2:0], shared with the LSU/control unit encoding;
  - constant TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module rr_arb2: 2-way round-robin picker (valid[1:0], last_grant -> grant one-hot), purely combinational.
- The FSM, muxing and timeout counter stay in dmem_arbiter.

Test Plan:
- Core load only:
  - Port 0 valid, addr=0x0000_0100, we=0; mem_gnt_i same cycle; mem_rvalid_i 3 cycles later with rdata=0x1234_5678.
  - Expect req_ready_o=01 in cycle 0, then rsp_valid_o=01 with rdata 0x1234_5678 in cycle 3.
- Contention fairness:
  - Both ports valid continuously, mem_gnt_i=1, mem_rvalid_i 1 cycle after each grant.
  - Grant order 0,1,0,1; mem_addr_o alternates between 0x10 and 0x20.
- Grant backpressure:
  - Port 1 valid store wdata=0xAA55_AA55, mem_gnt_i low for 4 cycles.
  - req_ready_o stays 00 and mem_* stays stable; ready pulses in the cycle mem_gnt_i rises.
- Spurious and reset:
  - mem_rvalid_i in IDLE gives spurious_o=1 for one cycle.
  - rst_ni=0 during WAIT, then mem_rvalid_i: no rsp_valid_o, spurious_o=1; the next tie grants port 0.
- Timeout, DMEM_ARB_TIMEOUT_EN defined, TIMEOUT=16:
  - Grant, no mem_rvalid_i.
  - Expect rsp_valid_o[owner]=1, rsp_rdata_o=0xDEAD_BEEF, rsp_err_o=1 after 16 WAIT cycles; a late mem_rvalid_i gives spurious_o=1.
- Simultaneous response and request:
  - mem_rvalid_i for port 0 while port 1 is valid.
  - Response delivered to port 0 this cycle; port 1 granted the next cycle.
